// File: rtl/fifo_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : fifo_pkg
// Brief   : Shared types and defaults for the FIFO read controller.
// Rev     : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default read-data width shared by the interface and the controller.
  localparam int DEFAULT_DATA_W = 16;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : fifo_rd_ctrl_if
// Brief     : FIFO read port plus valid/ready output stream.
//             master = controller side, slave = FIFO / downstream side.
// Rev       : 1.0 - initial release
// ============================================================================
interface fifo_rd_ctrl_if #(
  parameter int DATA_W = fifo_pkg::DEFAULT_DATA_W
) ();

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_ren;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  m_ready,
    output fifo_ren,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output m_ready,
    input  fifo_ren,
    input  m_valid,
    input  m_data
  );

endinterface
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : fifo_skid_buf
// Brief  : Two-entry in-order buffer. head_q is always the oldest word and
//          drives data_o straight from a register.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic [1:0]        occ_q,  occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              w_pop;
  logic              w_push;

  // Ignore a pop of an empty buffer and a push into a full one that is not
  // being drained in the same cycle; the controller never issues either.
  assign w_pop  = pop_i & (occ_q != 2'd0);
  assign w_push = push_i & ((occ_q != 2'd2) | w_pop);

  // Next-state of occupancy and both entries; order is kept by always
  // promoting tail into head when the head word leaves.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = head_q;
  assign occ_o   = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fifo_rd_ctrl
// Brief  : Drains a one-cycle-latency FIFO into a valid/ready stream with a
//          two-entry buffer, IDLE/RUN/DRAIN control and a delivered-word count.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] rd_cnt,
  fifo_rd_ctrl_if.master   bus
);

  state_e            state_q, state_d;
  logic              inflight_q;
  logic [CNT_W-1:0]  rd_cnt_q;

  logic [1:0]        w_occ;
  logic              w_buf_valid;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_valid;
  logic              w_pop;
  logic [2:0]        w_proj;
  logic              w_ren;

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign w_valid = sys_rst & w_buf_valid;
  assign w_pop   = w_valid & bus.m_ready;

  // Occupancy the buffer will have once the outstanding read lands and the
  // current pop retires; a new read is allowed only if that leaves room.
  assign w_proj = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_ren  = sys_rst & (state_q == RUN) & ~bus.fifo_empty & (w_proj < 3'd2);

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst),
    .push_i  (inflight_q),
    .data_i  (bus.fifo_rdata),
    .pop_i   (w_pop),
    .valid_o (w_buf_valid),
    .data_o  (w_buf_data),
    .occ_o   (w_occ)
  );

  // Next-state: leave DRAIN for IDLE only when nothing is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                               state_d = RUN;
        else if (!inflight_q && (w_occ == 2'd0))  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, outstanding-read flag and delivered-word counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= w_ren;
      if (w_pop) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fifo_ren = w_ren;
  assign bus.m_valid  = w_valid;
  assign bus.m_data   = sys_rst ? w_buf_data : '0;
  assign busy         = sys_rst & (state_q != IDLE);
  assign rd_cnt       = rd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_rd_ctrl
// Brief  : Directed self-checking bench for fifo_rd_ctrl with a FIFO model
//          and an in-order scoreboard of words read from that model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             enable;
  logic             busy;
  logic [CNT_W-1:0] rd_cnt;

  fifo_rd_ctrl_if #(.DATA_W(DATA_W)) bus ();

  fifo_rd_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .enable  (enable),
    .busy    (busy),
    .rd_cnt  (rd_cnt),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int               checks = 0;
  int               errors = 0;
  logic [15:0]      fq[$];
  logic [15:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  bit               fetched_last;
  bit               chk_en;
  bit               last_ren;
  int               cyc;
  int               pops;
  int               rens;
  int               first_pop_cyc;
  int               last_pop_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive FIFO status at negedge, sample just after, model the FIFO
  // read at the rising edge, then check the counter just after the edge.
  task automatic step();
    logic        ren_s, rst_s, pop_s, exp_valid;
    logic [15:0] w;
    int          nbuf;
    @(negedge sys_clk);
    bus.fifo_empty = (fq.size() == 0);
    #1;
    rst_s    = sys_rst;
    ren_s    = bus.fifo_ren;
    pop_s    = rst_s && bus.m_valid && bus.m_ready;
    last_ren = ren_s;
    if (ren_s) rens++;
    if (chk_en) begin
      nbuf      = exp_q.size() - (fetched_last ? 1 : 0);
      exp_valid = rst_s && (nbuf != 0);
      chk("m_valid", 32'(bus.m_valid), 32'(exp_valid));
      if (ren_s) chk("ren_while_empty", 32'(bus.fifo_empty), 32'd0);
      if (dut.state_q != RUN) chk("ren_outside_run", 32'(ren_s), 32'd0);
      if (pop_s) begin
        chk("pop_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        pops++;
        exp_cnt = exp_cnt + 4'd1;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    if (!rst_s) begin
      exp_q.delete();
      exp_cnt      = '0;
      fetched_last = 1'b0;
    end else begin
      fetched_last = 1'b0;
      if (ren_s && (fq.size() != 0)) begin
        w              = fq.pop_front();
        bus.fifo_rdata = w;
        exp_q.push_back(w);
        fetched_last   = 1'b1;
      end
    end
    bus.fifo_empty = (fq.size() == 0);
    if (chk_en) chk("rd_cnt", 32'(rd_cnt), 32'(exp_cnt));
  endtask

  initial begin
    sys_rst        = 1'b0;
    enable         = 1'b1;
    bus.m_ready    = 1'b1;
    bus.fifo_rdata = '0;
    exp_cnt        = '0;
    fetched_last   = 1'b0;
    chk_en         = 1'b0;
    cyc            = 0;
    pops           = 0;
    rens           = 0;
    first_pop_cyc  = -1;
    last_pop_cyc   = -1;
    for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
    bus.fifo_empty = 1'b0;

    // Reset held with enable=1 and a non-empty FIFO.
    step();
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_ren", 32'(bus.fifo_ren), 32'd0);
      chk("rst_m_data", 32'(bus.m_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_no_read", 32'(fq.size()), 32'd8);

    // Release: enable is first sampled at this edge, so no read yet.
    sys_rst = 1'b1;
    step();
    chk("first_ren_delay", 32'(last_ren), 32'd0);

    // Streaming of 0x0001..0x0008.
    pops          = 0;
    first_pop_cyc = -1;
    for (int n = 0; n < 40 && pops < 8; n++) step();
    chk("stream_count", 32'(pops), 32'd8);
    chk("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
    chk("stream_rd_cnt", 32'(rd_cnt), 32'd8);
    chk("stream_busy", 32'(busy), 32'd1);

    // Backpressure for 10 cycles mid-stream.
    pops = 0;
    for (int i = 0; i < 12; i++) fq.push_back(16'h0100 + 16'(i));
    bus.fifo_empty = 1'b0;
    #1;
    repeat (4) step();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(bus.m_valid), 32'd1);
      if (exp_q.size() != 0) chk("bp_hold", 32'(bus.m_data), 32'(exp_q[0]));
    end
    chk("bp_buffered", 32'(exp_q.size()), 32'd2);
    chk("bp_dut_occ", 32'(dut.u_buf.occ_q), 32'd2);
    chk("bp_ren_stop", 32'(bus.fifo_ren), 32'd0);
    bus.m_ready = 1'b1;
    for (int n = 0; n < 60 && (fq.size() != 0 || exp_q.size() != 0); n++) step();
    chk("bp_all_out", 32'(exp_q.size() + fq.size()), 32'd0);
    chk("bp_pops", 32'(pops), 32'd12);

    // Drain: drop enable in the cycle a read is issued.
    pops = 0;
    for (int i = 0; i < 4; i++) fq.push_back(16'h0200 + 16'(i));
    bus.fifo_empty = 1'b0;
    #1;
    for (int n = 0; n < 10 && !bus.fifo_ren; n++) step();
    chk("drain_ren_seen", 32'(bus.fifo_ren), 32'd1);
    enable = 1'b0;
    step();
    chk("drain_state", 32'(dut.state_q), 32'(DRAIN));
    chk("drain_busy", 32'(busy), 32'd1);
    for (int n = 0; n < 20 && busy; n++) step();
    chk("drain_idle", 32'(dut.state_q), 32'(IDLE));
    chk("drain_busy_low", 32'(busy), 32'd0);
    chk("drain_delivered", 32'(exp_q.size()), 32'd0);
    chk("drain_pops", 32'(pops), 32'd1);
    chk("drain_left", 32'(fq.size()), 32'd3);
    fq.delete();
    bus.fifo_empty = 1'b1;

    // Single-word FIFO.
    enable = 1'b1;
    pops   = 0;
    rens   = 0;
    fq.push_back(16'hA5A5);
    bus.fifo_empty = 1'b0;
    repeat (8) step();
    chk("one_ren", 32'(rens), 32'd1);
    chk("one_pop", 32'(pops), 32'd1);
    chk("one_empty_ren", 32'(bus.fifo_ren), 32'd0);

    // Counter wrap with a 4-bit counter: 17 words from zero.
    sys_rst = 1'b0;
    step();
    sys_rst = 1'b1;
    chk("wrap_reset_cnt", 32'(rd_cnt), 32'd0);
    pops = 0;
    for (int i = 0; i < 17; i++) fq.push_back(16'h0300 + 16'(i));
    bus.fifo_empty = 1'b0;
    for (int n = 0; n < 80 && pops < 17; n++) step();
    chk("wrap_pops", 32'(pops), 32'd17);
    chk("wrap_rd_cnt", 32'(rd_cnt), 32'd1);

    // Reset while the buffer is full.
    for (int i = 0; i < 6; i++) fq.push_back(16'h0400 + 16'(i));
    bus.fifo_empty = 1'b0;
    bus.m_ready    = 1'b0;
    repeat (6) step();
    chk("mid_occ2", 32'(exp_q.size()), 32'd2);
    chk("mid_dut_occ", 32'(dut.u_buf.occ_q), 32'd2);
    chk("mid_valid_pre", 32'(bus.m_valid), 32'd1);
    sys_rst = 1'b0;
    step();
    chk("mid_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_rd_cnt", 32'(rd_cnt), 32'd0);
    sys_rst     = 1'b1;
    enable      = 1'b0;
    bus.m_ready = 1'b1;
    pops        = 0;
    repeat (4) step();
    chk("mid_no_ghost", 32'(pops), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
